// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared constants for the instruction fetch queue.
//   FQ_DEPTH  : default number of queue entries (power of two, 2..16)
//   FQ_WIDTH  : default bit width of the PC and instruction fields
//   NOP_INSTR : instruction word presented when the queue is empty
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

  localparam int          FQ_DEPTH  = 4;
  localparam int          FQ_WIDTH  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_ram.sv
// ---------------------------------------------------------------------------
// fetch_queue_ram
//   DEPTH x DW storage array: one synchronous write port and one
//   asynchronous (combinational) read port. Every entry is cleared by the
//   asynchronous active-low reset.
//   Ports:
//     clk_i   : clock, writes on posedge
//     rst_i   : asynchronous active-low reset, clears all entries
//     we_i    : write enable
//     waddr_i : write address
//     wdata_i : write data
//     raddr_i : read address
//     rdata_o : read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  parameter  int DW    = 2 * FQ_WIDTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : fetch_queue_ram

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   First-word-fall-through queue between the fetch and decode stages.
//   Holds {pc, instr} pairs; the head is visible on pc_o/instr_o whenever
//   valid_o=1, and both read as zero (NOP) otherwise.
//   Ports:
//     clk_i    : clock, all state updates on posedge
//     rst_i    : asynchronous active-low reset
//     start_i  : run enable; low freezes pointers, count and storage
//     push_i   : fetch presents pc_i/instr_i
//     pc_i     : PC of fetched instruction
//     instr_i  : fetched instruction word
//     pop_i    : decode consumes the head entry
//     flush_i  : discard every queued entry (branch/jump taken)
//     valid_o  : head entry present
//     pc_o     : head PC (0 when empty)
//     instr_o  : head instruction (NOP when empty)
//     full_o   : queue full, used as PC hold by fetch
//     count_o  : current occupancy
//
//   Handshake: a push is taken on a clock edge where start_i=1, flush_i=0,
//   push_i=1 and the queue is not full (or a pop is taken on the same edge);
//   a pop is taken where start_i=1, flush_i=0, pop_i=1 and valid_o=1. Any
//   request not taken leaves state untouched; there is no back-pressure
//   beyond full_o/valid_o, which depend on registered state only.
// ---------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  parameter  int WIDTH = FQ_WIDTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] instr_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] instr_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;
  logic               push_ok, pop_ok;
  logic               full, valid;
  logic [2*WIDTH-1:0] rdata;

  assign full  = (count_q == CW'(DEPTH));
  assign valid = (count_q != '0);

  // A pop on the same edge frees a slot, so push is allowed even when full.
  assign pop_ok  = start_i && !flush_i && pop_i && valid;
  assign push_ok = start_i && !flush_i && push_i && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (start_i && flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .DW    (2 * WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i ({pc_i, instr_i}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign valid_o = valid;
  assign full_o  = full;
  assign count_o = count_q;
  assign pc_o    = valid ? rdata[2*WIDTH-1:WIDTH] : '0;
  assign instr_o = valid ? rdata[WIDTH-1:0]       : WIDTH'(NOP_INSTR);

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int D  = 4;
  localparam int W  = 32;
  localparam int CW = $clog2(D) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic          push_i = 1'b0;
  logic [W-1:0]  pc_i = '0;
  logic [W-1:0]  instr_i = '0;
  logic          pop_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_o;
  logic [W-1:0]  pc_o;
  logic [W-1:0]  instr_o;
  logic          full_o;
  logic [CW-1:0] count_o;

  always #5 clk_i = ~clk_i;

  fetch_queue #(.DEPTH(D), .WIDTH(W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .push_i  (push_i),
    .pc_i    (pc_i),
    .instr_i (instr_i),
    .pop_i   (pop_i),
    .flush_i (flush_i),
    .valid_o (valid_o),
    .pc_o    (pc_o),
    .instr_o (instr_o),
    .full_o  (full_o),
    .count_o (count_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an ideal bounded queue updated from the interface rules.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      exp_q.delete();
    end else if (start_i) begin
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (pop_i && exp_q.size() > 0) void'(exp_q.pop_front());
        if (push_i && exp_q.size() < D) exp_q.push_back({pc_i, instr_i});
      end
    end
  end

  // Monitor: compares DUT outputs with the model away from the active edge.
  always @(negedge clk_i) begin
    logic [W-1:0] e_pc, e_in;
    e_pc = '0;
    e_in = '0;
    if (exp_q.size() > 0) begin
      e_pc = exp_q[0][2*W-1:W];
      e_in = exp_q[0][W-1:0];
    end
    chk("mon_count", 64'(count_o), 64'(exp_q.size()));
    chk("mon_valid", 64'(valid_o), 64'(exp_q.size() != 0));
    chk("mon_full",  64'(full_o),  64'(exp_q.size() == D));
    chk("mon_pc",    64'(pc_o),    64'(e_pc));
    chk("mon_instr", 64'(instr_o), 64'(e_in));
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic st, input logic ps, input logic [W-1:0] pc,
                       input logic [W-1:0] ins, input logic pp, input logic fl);
    start_i = st;
    push_i  = ps;
    pc_i    = pc;
    instr_i = ins;
    pop_i   = pp;
    flush_i = fl;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [W-1:0] pc, input logic [W-1:0] ins);
    cycle(1'b1, 1'b1, pc, ins, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cycle(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < D + 1; i++) pop();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_count", 64'(count_o), 64'(0));
    chk("rst_pc",    64'(pc_o),    64'(0));
    chk("rst_instr", 64'(instr_o), 64'(0));
    chk("rst_full",  64'(full_o),  64'(0));
    #10 rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Three pushes, head visible one cycle after the first, then ordered pops.
    push(32'h00, 32'hA);
    chk("fwft_valid", 64'(valid_o), 64'(1));
    chk("fwft_pc",    64'(pc_o),    64'(32'h00));
    push(32'h04, 32'hB);
    push(32'h08, 32'hC);
    chk("three_count", 64'(count_o), 64'(3));
    for (int i = 0; i < 3; i++) begin
      chk("order_instr", 64'(instr_o), 64'(32'hA + i));
      pop();
    end
    chk("empty_after_pops", 64'(count_o), 64'(0));

    // Fill to full; fifth push dropped.
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'(100 + i));
    chk("full_at_4", 64'(full_o), 64'(1));
    push(32'h10, 32'h1234);
    chk("drop_count", 64'(count_o), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk("full_order_pc", 64'(pc_o), 64'(i * 4));
      pop();
    end
    chk("no_0x10", 64'(valid_o), 64'(0));

    // Full queue, simultaneous push/pop, then pointer wrap.
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'(200 + i));
    cycle(1'b1, 1'b1, 32'h20, 32'h2020, 1'b1, 1'b0);
    chk("pp_full_count", 64'(count_o), 64'(4));
    chk("pp_full_head",  64'(pc_o),    64'(32'h04));
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b1, 32'(32'h24 + 4 * k), 32'(300 + k), 1'b1, 1'b0);
    chk("wrap_count", 64'(count_o), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk("wrap_order_pc", 64'(pc_o), 64'(32'h44 + 4 * i));
      pop();
    end

    // Flush drops queued entries and a same-cycle push.
    for (int i = 0; i < 3; i++) push(32'(32'h30 + 4 * i), 32'(i));
    cycle(1'b1, 1'b1, 32'h40, 32'h4040, 1'b0, 1'b1);
    chk("flush_count", 64'(count_o), 64'(0));
    chk("flush_valid", 64'(valid_o), 64'(0));
    chk("flush_pc",    64'(pc_o),    64'(0));
    idle();
    chk("flush_no_0x40", 64'(count_o), 64'(0));

    // start_i low freezes everything.
    push(32'h60, 32'h6);
    push(32'h64, 32'h7);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 32'h70, 32'h7070, 1'b1, (i == 2));
      chk("hold_count", 64'(count_o), 64'(2));
      chk("hold_pc",    64'(pc_o),    64'(32'h60));
    end

    // Asynchronous reset pulse between clock edges.
    #3 rst_i = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_o), 64'(0));
    chk("arst_count", 64'(count_o), 64'(0));
    chk("arst_pc",    64'(pc_o),    64'(0));
    chk("arst_instr", 64'(instr_o), 64'(0));
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    push(32'h80, 32'h8888);
    chk("post_rst_valid", 64'(valid_o), 64'(1));
    chk("post_rst_pc",    64'(pc_o),    64'(32'h80));
    drain();

    // Randomized traffic; the monitor checks every cycle.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 6), $urandom, $urandom,
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 19) == 0));
    end
    drain();
    chk("final_empty", 64'(count_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule : tb_fetch_queue
